// File: rtl/sparc_ifu_pcseq_mt.sv
// rtl/sparc_ifu_pcseq_mt.sv - per-thread fetch-PC sequencer with +1/+2 advance, redirect and overflow/wrap flags
module sparc_ifu_pcseq_mt #(
    parameter int WIDTH = 46,
    parameter int NTHR  = 4,
    parameter int TIDW  = 2
) (
    input  logic                  rclk,
    input  logic                  reset,
    input  logic                  redir_vld,
    input  logic [TIDW-1:0]       redir_tid,
    input  logic [WIDTH-1:0]      redir_pc,
    input  logic                  adv_vld,
    input  logic [TIDW-1:0]       adv_tid,
    input  logic                  adv_dbl,
    output logic                  out_vld,
    output logic [TIDW-1:0]       out_tid,
    output logic [WIDTH-1:0]      out_pc,
    output logic                  out_ofl,
    output logic                  out_wrap,
    output logic [NTHR*WIDTH-1:0] thr_pc,
    output logic [NTHR-1:0]       thr_ofl
);

    logic [WIDTH-1:0] pc_q [NTHR];
    logic [WIDTH-1:0] adv_old;
    logic [WIDTH:0]   inc;
    logic [WIDTH-1:0] new_pc;
    logic             ofl;
    logic             wrap;
    logic             adv_acc;

    always_comb begin
        adv_old = pc_q[adv_tid];
        inc     = {1'b0, adv_old} + {{(WIDTH-1){1'b0}}, adv_dbl, ~adv_dbl};
        new_pc  = inc[WIDTH-1:0];
        wrap    = inc[WIDTH];
        ofl     = ~adv_old[WIDTH-1] & new_pc[WIDTH-1];
        // a redirect to the thread being advanced wins and the advance is dropped
        adv_acc = adv_vld & ~(redir_vld & (redir_tid == adv_tid));
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            for (int t = 0; t < NTHR; t++) begin
                pc_q[t]    <= '0;
                thr_ofl[t] <= 1'b0;
            end
        end else begin
            for (int t = 0; t < NTHR; t++) begin
                if (redir_vld && (redir_tid == TIDW'(t))) begin
                    pc_q[t]    <= redir_pc;
                    thr_ofl[t] <= 1'b0;
                end else if (adv_acc && (adv_tid == TIDW'(t))) begin
                    pc_q[t]    <= new_pc;
                    thr_ofl[t] <= thr_ofl[t] | ofl;
                end
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            out_vld  <= 1'b0;
            out_tid  <= '0;
            out_pc   <= '0;
            out_ofl  <= 1'b0;
            out_wrap <= 1'b0;
        end else begin
            out_vld <= adv_acc;
            if (adv_acc) begin
                out_tid  <= adv_tid;
                out_pc   <= new_pc;
                out_ofl  <= ofl;
                out_wrap <= wrap;
            end else begin
                out_ofl  <= 1'b0;
                out_wrap <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NTHR; g++) begin : g_thr_pc
        assign thr_pc[g*WIDTH +: WIDTH] = pc_q[g];
    end

endmodule

// File: tb/tb_sparc_ifu_pcseq_mt.sv
// tb/tb_sparc_ifu_pcseq_mt.sv - self-checking bench for sparc_ifu_pcseq_mt (46b/4 threads plus 8b/8 threads)
module tb_sparc_ifu_pcseq_mt;

    localparam int W = 46;
    localparam longint unsigned MOD  = 64'h1 << W;
    localparam longint unsigned HALF = 64'h1 << (W - 1);

    logic          rclk = 1'b0;
    logic          reset = 1'b1;
    logic          redir_vld = 1'b0;
    logic [1:0]    redir_tid = '0;
    logic [W-1:0]  redir_pc = '0;
    logic          adv_vld = 1'b0;
    logic [1:0]    adv_tid = '0;
    logic          adv_dbl = 1'b0;
    logic          out_vld;
    logic [1:0]    out_tid;
    logic [W-1:0]  out_pc;
    logic          out_ofl;
    logic          out_wrap;
    logic [4*W-1:0] thr_pc;
    logic [3:0]    thr_ofl;

    logic          b_redir_vld = 1'b0;
    logic [2:0]    b_redir_tid = '0;
    logic [7:0]    b_redir_pc = '0;
    logic          b_adv_vld = 1'b0;
    logic [2:0]    b_adv_tid = '0;
    logic          b_adv_dbl = 1'b0;
    logic          b_out_vld;
    logic [2:0]    b_out_tid;
    logic [7:0]    b_out_pc;
    logic          b_out_ofl;
    logic          b_out_wrap;
    logic [63:0]   b_thr_pc;
    logic [7:0]    b_thr_ofl;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    sparc_ifu_pcseq_mt #(.WIDTH(W), .NTHR(4), .TIDW(2)) dut_a (
        .rclk(rclk), .reset(reset),
        .redir_vld(redir_vld), .redir_tid(redir_tid), .redir_pc(redir_pc),
        .adv_vld(adv_vld), .adv_tid(adv_tid), .adv_dbl(adv_dbl),
        .out_vld(out_vld), .out_tid(out_tid), .out_pc(out_pc),
        .out_ofl(out_ofl), .out_wrap(out_wrap),
        .thr_pc(thr_pc), .thr_ofl(thr_ofl)
    );

    sparc_ifu_pcseq_mt #(.WIDTH(8), .NTHR(8), .TIDW(3)) dut_b (
        .rclk(rclk), .reset(reset),
        .redir_vld(b_redir_vld), .redir_tid(b_redir_tid), .redir_pc(b_redir_pc),
        .adv_vld(b_adv_vld), .adv_tid(b_adv_tid), .adv_dbl(b_adv_dbl),
        .out_vld(b_out_vld), .out_tid(b_out_tid), .out_pc(b_out_pc),
        .out_ofl(b_out_ofl), .out_wrap(b_out_wrap),
        .thr_pc(b_thr_pc), .thr_ofl(b_thr_ofl)
    );

    always #5 rclk = ~rclk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: plain modulo arithmetic on integers, one PC per thread
    longint unsigned m_pc [4];
    bit              m_ofl [4];
    bit              m_vld, m_oofl, m_owrap;
    int              m_tid;
    longint unsigned m_opc;
    longint unsigned m_old, m_sum, m_new;

    initial begin
        for (int t = 0; t < 4; t++) begin
            m_pc[t] = 0;
            m_ofl[t] = 0;
        end
        m_vld = 0; m_oofl = 0; m_owrap = 0; m_tid = 0; m_opc = 0;
    end

    always @(posedge rclk) begin
        if (reset) begin
            for (int t = 0; t < 4; t++) begin
                m_pc[t] = 0;
                m_ofl[t] = 0;
            end
            m_vld = 0; m_oofl = 0; m_owrap = 0; m_tid = 0; m_opc = 0;
        end else begin
            if (adv_vld && !(redir_vld && redir_tid == adv_tid)) begin
                m_old   = m_pc[adv_tid];
                m_sum   = m_old + (adv_dbl ? 2 : 1);
                m_new   = m_sum % MOD;
                m_vld   = 1;
                m_tid   = int'(adv_tid);
                m_opc   = m_new;
                m_owrap = (m_sum >= MOD);
                m_oofl  = (m_old < HALF) && (m_new >= HALF);
                m_pc[adv_tid]  = m_new;
                m_ofl[adv_tid] = m_ofl[adv_tid] | m_oofl;
            end else begin
                m_vld = 0; m_oofl = 0; m_owrap = 0;
            end
            if (redir_vld) begin
                m_pc[redir_tid]  = longint'(redir_pc);
                m_ofl[redir_tid] = 0;
            end
        end
    end

    always @(negedge rclk) begin
        if (cmp_en) begin
            chk("cmp out_vld", 64'(out_vld), 64'(m_vld));
            chk("cmp out_tid", 64'(out_tid), 64'(m_tid));
            chk("cmp out_pc", 64'(out_pc), m_opc);
            chk("cmp out_ofl", 64'(out_ofl), 64'(m_oofl));
            chk("cmp out_wrap", 64'(out_wrap), 64'(m_owrap));
            for (int t = 0; t < 4; t++) begin
                chk($sformatf("cmp thr_pc[%0d]", t), 64'(thr_pc[t*W +: W]), m_pc[t]);
                chk($sformatf("cmp thr_ofl[%0d]", t), 64'(thr_ofl[t]), 64'(m_ofl[t]));
            end
        end
    end

    task automatic cyc(input logic rv, input logic [1:0] rt, input logic [W-1:0] rp,
                       input logic av, input logic [1:0] at, input logic ad);
        redir_vld = rv; redir_tid = rt; redir_pc = rp;
        adv_vld = av; adv_tid = at; adv_dbl = ad;
        @(posedge rclk);
        @(negedge rclk);
    endtask

    task automatic bcyc(input logic rv, input logic [2:0] rt, input logic [7:0] rp,
                        input logic av, input logic [2:0] at, input logic ad);
        b_redir_vld = rv; b_redir_tid = rt; b_redir_pc = rp;
        b_adv_vld = av; b_adv_tid = at; b_adv_dbl = ad;
        @(posedge rclk);
        @(negedge rclk);
    endtask

    initial begin
        reset = 1'b1;
        cyc(0, 0, 0, 1, 1, 0);
        cmp_en = 1'b1;
        chk("reset out_vld", 64'(out_vld), 0);
        chk("reset thr_pc", 64'(|thr_pc), 0);
        chk("reset thr_ofl", 64'(thr_ofl), 0);
        reset = 1'b0;

        cyc(0, 0, 0, 1, 1, 0);
        chk("b2b pc 1", 64'(out_pc), 1);
        cyc(0, 0, 0, 1, 1, 1);
        chk("b2b pc 3", 64'(out_pc), 3);
        cyc(0, 0, 0, 1, 1, 0);
        chk("b2b pc 4", 64'(out_pc), 4);
        chk("b2b vld", 64'(out_vld), 1);

        cyc(1, 2, 46'h1FFF_FFFF_FFFF, 0, 0, 0);
        cyc(0, 0, 0, 1, 2, 1);
        chk("hole pc", 64'(out_pc), 64'h2000_0000_0001);
        chk("hole ofl", 64'(out_ofl), 1);
        cyc(0, 0, 0, 1, 2, 0);
        chk("hole ofl once", 64'(out_ofl), 0);
        chk("hole sticky", 64'(thr_ofl[2]), 1);
        cyc(1, 2, 46'h0, 0, 0, 0);
        chk("hole clear", 64'(thr_ofl[2]), 0);

        cyc(1, 3, 46'h3FFF_FFFF_FFFF, 0, 0, 0);
        cyc(0, 0, 0, 1, 3, 0);
        chk("wrap1 pc", 64'(out_pc), 0);
        chk("wrap1 wrap", 64'(out_wrap), 1);
        chk("wrap1 ofl", 64'(out_ofl), 0);
        cyc(1, 3, 46'h3FFF_FFFF_FFFE, 0, 0, 0);
        cyc(0, 0, 0, 1, 3, 1);
        chk("wrap2 pc", 64'(out_pc), 0);
        chk("wrap2 wrap", 64'(out_wrap), 1);

        cyc(1, 0, 46'h100, 1, 0, 0);
        chk("coll same pc", 64'(thr_pc[0 +: W]), 64'h100);
        chk("coll same vld", 64'(out_vld), 0);
        cyc(1, 0, 46'h100, 1, 1, 0);
        chk("coll diff pc0", 64'(thr_pc[0 +: W]), 64'h100);
        chk("coll diff vld", 64'(out_vld), 1);
        chk("coll diff pc", 64'(out_pc), 5);
        cyc(0, 0, 0, 1, 0, 0);
        chk("redir then adv", 64'(out_pc), 64'h101);

        cyc(0, 0, 0, 1, 1, 1);
        reset = 1'b1;
        cyc(0, 0, 0, 1, 1, 0);
        chk("midrst vld", 64'(out_vld), 0);
        chk("midrst pc", 64'(|thr_pc), 0);
        reset = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);

        cmp_en = 1'b0;
        bcyc(1, 7, 8'h7F, 0, 0, 0);
        bcyc(0, 0, 0, 1, 7, 0);
        chk("w8 pc 80", 64'(b_out_pc), 64'h80);
        chk("w8 ofl", 64'(b_out_ofl), 1);
        chk("w8 tid", 64'(b_out_tid), 7);
        bcyc(1, 7, 8'hFF, 0, 0, 0);
        bcyc(0, 0, 0, 1, 7, 0);
        chk("w8 pc 0", 64'(b_out_pc), 0);
        chk("w8 wrap", 64'(b_out_wrap), 1);
        chk("w8 others", 64'(b_thr_pc[55:0]), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
